axi_rx_buffer: RTL and testbench
================================

Name: axi_rx_buffer

Overview:
- Receive stage directly downstream of the core's AXI-style master. Consumes its valid/message handshake and buffers 32-bit messages in a small FIFO.
- Presents the buffered messages to the consuming processor/datapath stage with first-word-fall-through semantics.
- Inserts a guard cycle after every accept. The master keeps valid high for one extra cycle, because it uses a registered copy of ready to drop valid; the guard cycle stops that extra cycle from being captured as a duplicate.

Parameters:
- DATA_W, 32, message width in bits.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- GUARD_CYCLES, 1, cycles ready_o is held low after each accept; range 0..3, and 0 disables the guard.

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- valid_i  in  1  upstream message valid.
- message_i  in  DATA_W  upstream message.
- ready_o  out  1  ready for a new message.
- pop_i  in  1  consumer takes the head entry this cycle.
- data_o  out  DATA_W  head entry (FWFT); all zeros when empty.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values: ready_o=0 during the reset cycle, then 1 on the first cycle after reset deasserts. empty_o=1, full_o=0, count_o=0, data_o=0. Read/write pointers=0, guard counter=0, state=S_RDY.
- Accept condition: accept = valid_i && ready_o. On accept, message_i is written at wr_ptr and wr_ptr increments modulo DEPTH. The write is visible on data_o the next cycle if the FIFO was empty.
- ready_o is a function of registered state only: ready_o = (state==S_RDY) && !full. There is no combinational path from valid_i or pop_i to ready_o.
- State machine, S_RDY: on accept, go to S_GUARD if GUARD_CYCLES>0 and load guard_cnt=GUARD_CYCLES-1; otherwise stay in S_RDY.
- State machine, S_GUARD: ready_o=0. If guard_cnt==0, go to S_RDY; else decrement guard_cnt. valid_i is ignored during S_GUARD.
- Full is not a separate state. While full, ready_o=0 and state stays S_RDY.
- Pop: pop_i while !empty_o advances rd_ptr modulo DEPTH. pop_i while empty_o is ignored; no pointer or count change.
- Simultaneous accept and pop: count is unchanged and both pointers advance. With count==1, data_o shows the new entry on the next cycle.
- Full is computed before the pop. A pop while full does not raise ready_o in the same cycle; ready_o rises the cycle after.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count_o is kept separately, so full and empty are never ambiguous.
- Reset mid-operation: all entries are logically discarded (count=0), state=S_RDY, guard aborted. Memory contents need not be cleared, but data_o must read 0 while empty.
- Latency: message_i accepted at cycle t appears on data_o at t+1 when the FIFO was empty.

Optional Feature:
- Macro: AXI_RX_DROP_CNT_EN.
- When defined:
  - adds output drop_cnt_o [15:0]. It increments, saturating at 16'hFFFF, on each cycle with valid_i=1 && ready_o=0 && state==S_RDY (i.e. stalled by full).
  - Reset value is 0.
  - Adds input drop_clr_i. drop_clr_i=1 zeroes the counter next cycle and takes priority over an increment in the same cycle.
- When undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package axi_pkg:
  - localparam AXI_DATA_W=32;
  - typedef enum for rx state {S_RDY, S_GUARD};
  - helper function for count width ($clog2(DEPTH)+1).
- One sub-module: sync_fifo_fwft. It holds storage, pointers, count, full/empty and FWFT data_o gated to 0 when empty.
- The top level holds the guard FSM, ready_o generation and the optional drop counter.

Test Plan:
- Single message, driven by a master model that drops valid one cycle after it samples a registered ready: message 32'hDEAD_BEEF with valid held 2 cycles -> exactly one accept, count_o=1, data_o=32'hDEAD_BEEF, ready_o low for 1 cycle then high.
- Fill with no pops: 4 messages 1,2,3,4 -> full_o=1, ready_o=0 while a 5th message is held valid. Then pop once -> data_o=2, count_o=3, ready_o=1 on the following cycle, and the 5th message is accepted.
- Wrap-around: push and pop 10 sequential values A0..A9 with interleaved pops -> read order is exactly A0..A9, and count_o never exceeds 4 or underflows.
- Simultaneous accept and pop with count_o=1 -> count stays 1 and data_o advances to the new word; pop_i on empty -> no change.
- Reset mid-guard with count_o=3: assert reset_i for 1 cycle -> count_o=0, empty_o=1, data_o=0, and ready_o=1 on the cycle after reset deasserts.
- With AXI_RX_DROP_CNT_EN defined and the FIFO full: hold valid_i for 5 cycles -> drop_cnt_o=5; then assert drop_clr_i together with a stall cycle -> drop_cnt_o=0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI receive buffer.
package axi_pkg;

    localparam int AXI_DATA_W = 32;

    typedef enum logic {
        S_RDY,
        S_GUARD
    } rx_state_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a separate occupancy count.
module sync_fifo_fwft
    import axi_pkg::*;
#(
    parameter int DATA_W = AXI_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        wr_en_i,
    input  logic [DATA_W-1:0]           wr_data_i,
    input  logic                        rd_en_i,
    output logic [DATA_W-1:0]           data_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_wr, do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;
    // Stale storage must never leak out while empty.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/axi_rx_buffer.sv
// Receive buffer with post-accept guard cycles in front of a FWFT FIFO.
// Optional stall counter enabled by defining AXI_RX_DROP_CNT_EN.
module axi_rx_buffer
    import axi_pkg::*;
#(
    parameter int DATA_W       = AXI_DATA_W,
    parameter int DEPTH        = 4,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        valid_i,
    input  logic [DATA_W-1:0]           message_i,
    output logic                        ready_o,
    input  logic                        pop_i,
    output logic [DATA_W-1:0]           data_o,
    output logic                        empty_o,
    output logic                        full_o,
`ifdef AXI_RX_DROP_CNT_EN
    input  logic                        drop_clr_i,
    output logic [15:0]                 drop_cnt_o,
`endif
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    rx_state_e  state_q;
    logic [1:0] guard_q;
    logic       accept;

    assign ready_o = (state_q == S_RDY) && !full_o && !reset_i;
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_RDY;
            guard_q <= '0;
        end else begin
            unique case (state_q)
                S_RDY: begin
                    if (accept && GUARD_CYCLES > 0) begin
                        state_q <= S_GUARD;
                        guard_q <= 2'(GUARD_CYCLES - 1);
                    end
                end
                S_GUARD: begin
                    // Swallows the master's late valid after an accept.
                    if (guard_q == '0) begin
                        state_q <= S_RDY;
                    end else begin
                        guard_q <= guard_q - 2'd1;
                    end
                end
                default: state_q <= S_RDY;
            endcase
        end
    end

`ifdef AXI_RX_DROP_CNT_EN
    logic [15:0] drop_q;
    logic        stall;

    assign stall      = valid_i && !ready_o && (state_q == S_RDY);
    assign drop_cnt_o = drop_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || drop_clr_i) begin
            drop_q <= '0;
        end else if (stall && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end
`endif

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_en_i   (accept),
        .wr_data_i (message_i),
        .rd_en_i   (pop_i),
        .data_o    (data_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .count_o   (count_o)
    );

endmodule

// File: tb/tb_axi_rx_buffer.sv
// Directed self-checking bench for axi_rx_buffer (DEPTH=4, one guard cycle).
module tb_axi_rx_buffer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic [31:0] message_i;
    logic        ready_o;
    logic        pop_i;
    logic [31:0] data_o;
    logic        empty_o;
    logic        full_o;
    logic [2:0]  count_o;
`ifdef AXI_RX_DROP_CNT_EN
    logic        drop_clr_i;
    logic [15:0] drop_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    axi_rx_buffer dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .valid_i    (valid_i),
        .message_i  (message_i),
        .ready_o    (ready_o),
        .pop_i      (pop_i),
        .data_o     (data_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
`ifdef AXI_RX_DROP_CNT_EN
        .drop_clr_i (drop_clr_i),
        .drop_cnt_o (drop_cnt_o),
`endif
        .count_o    (count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_guard(input logic [31:0] m);
        valid_i   = 1'b1;
        message_i = m;
        tick();
        valid_i = 1'b0;
        tick();
    endtask

    initial begin
        int cnt;
        int rd;
        reset_i   = 1'b1;
        valid_i   = 1'b0;
        message_i = '0;
        pop_i     = 1'b0;
`ifdef AXI_RX_DROP_CNT_EN
        drop_clr_i = 1'b0;
`endif
        tick();
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        reset_i = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ready_o), 32'd1);

        // Single message, valid held two cycles.
        valid_i   = 1'b1;
        message_i = 32'hDEAD_BEEF;
        tick();
        chk("s1_count", 32'(count_o), 32'd1);
        chk("s1_data", data_o, 32'hDEAD_BEEF);
        chk("s1_guard_ready", 32'(ready_o), 32'd0);
        tick();
        valid_i = 1'b0;
        chk("s1_one_accept", 32'(count_o), 32'd1);
        chk("s1_ready_back", 32'(ready_o), 32'd1);
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        chk("s1_popped_empty", 32'(empty_o), 32'd1);
        chk("s1_popped_data", data_o, 32'd0);

        // Fill then pop while a fifth message waits.
        for (int i = 1; i <= 4; i++) push_guard(32'(i));
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_count", 32'(count_o), 32'd4);
        chk("fill_data", data_o, 32'd1);
        valid_i   = 1'b1;
        message_i = 32'd5;
        chk("fill_ready", 32'(ready_o), 32'd0);
        tick();
        chk("fill_stall_count", 32'(count_o), 32'd4);
        chk("fill_stall_ready", 32'(ready_o), 32'd0);
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        chk("fill_pop_data", data_o, 32'd2);
        chk("fill_pop_count", 32'(count_o), 32'd3);
        chk("fill_pop_ready", 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        chk("fill_fifth_count", 32'(count_o), 32'd4);
        for (int e = 2; e <= 5; e++) begin
            chk("fill_drain", data_o, 32'(e));
            pop_i = 1'b1;
            tick();
            pop_i = 1'b0;
        end
        chk("fill_drain_empty", 32'(empty_o), 32'd1);

        // Wrap-around with pops during guard cycles.
        cnt = 0;
        rd  = 0;
        for (int i = 0; i < 10; i++) begin
            valid_i   = 1'b1;
            message_i = 32'hA0 + 32'(i);
            tick();
            valid_i = 1'b0;
            cnt++;
            if (i >= 2) begin
                chk("wrap_order", data_o, 32'hA0 + 32'(rd));
                pop_i = 1'b1;
                tick();
                pop_i = 1'b0;
                rd++;
                cnt--;
            end else begin
                tick();
            end
            chk("wrap_count", 32'(count_o), 32'(cnt));
        end
        while (rd < 10) begin
            chk("wrap_tail", data_o, 32'hA0 + 32'(rd));
            pop_i = 1'b1;
            tick();
            pop_i = 1'b0;
            rd++;
        end
        chk("wrap_empty", 32'(empty_o), 32'd1);

        // Simultaneous accept and pop at count 1, then pop on empty.
        push_guard(32'h111);
        valid_i   = 1'b1;
        message_i = 32'h222;
        pop_i     = 1'b1;
        tick();
        valid_i = 1'b0;
        pop_i   = 1'b0;
        chk("sim_count", 32'(count_o), 32'd1);
        chk("sim_data", data_o, 32'h222);
        tick();
        pop_i = 1'b1;
        tick();
        chk("sim_drained", 32'(empty_o), 32'd1);
        tick();
        pop_i = 1'b0;
        chk("empty_pop_count", 32'(count_o), 32'd0);
        chk("empty_pop_data", data_o, 32'd0);
        push_guard(32'h333);
        chk("empty_pop_ptrs", data_o, 32'h333);
        chk("empty_pop_cnt1", 32'(count_o), 32'd1);
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;

        // Reset during a guard cycle with three entries.
        push_guard(32'h10);
        push_guard(32'h20);
        valid_i   = 1'b1;
        message_i = 32'h30;
        tick();
        valid_i = 1'b0;
        chk("mid_count", 32'(count_o), 32'd3);
        chk("mid_guard_ready", 32'(ready_o), 32'd0);
        reset_i = 1'b1;
        tick();
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_empty", 32'(empty_o), 32'd1);
        chk("mid_rst_data", data_o, 32'd0);
        reset_i = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready_o), 32'd1);

`ifdef AXI_RX_DROP_CNT_EN
        chk("drop_rst", 32'(drop_cnt_o), 32'd0);
        for (int i = 0; i < 4; i++) push_guard(32'(i));
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("drop_five", 32'(drop_cnt_o), 32'd5);
        drop_clr_i = 1'b1;
        tick();
        drop_clr_i = 1'b0;
        valid_i    = 1'b0;
        chk("drop_clr", 32'(drop_cnt_o), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
